// File: rtl/mem_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size and fault codes.
package mem_lsu_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // Encodings match the DATA_SIZE / DSIZE pins.
  typedef enum logic [1:0] {
    SizeNone = 2'b00,
    SizeByte = 2'b01,
    SizeHalf = 2'b10,
    SizeWord = 2'b11
  } size_e;

  // Encodings match the FAULT_CODE pin.
  typedef enum logic [1:0] {
    FaultNone     = 2'b00,
    FaultMisalign = 2'b01,
    FaultSize     = 2'b10,
    FaultTimeout  = 2'b11
  } fault_e;

  // Half needs an even address, word needs a 4-byte aligned one.
  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (size == SizeHalf) mis = off[0];
    if (size == SizeWord) mis = |off;
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte-lane logic: store lane enables and replication, load extraction and extension.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  size_e       st_size_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_dbe_o,
  output logic [31:0] st_dout_o,
  input  logic [1:0]  ld_off_i,
  input  size_e       ld_size_i,
  input  logic        ld_signed_i,
  input  logic [31:0] ld_din_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  // Store side: lane enables and data replicated onto every lane the size can occupy.
  always_comb begin
    st_dbe_o  = 4'b0000;
    st_dout_o = st_data_i;
    unique case (st_size_i)
      SizeByte: begin
        st_dbe_o  = 4'b0001 << st_off_i;
        st_dout_o = {4{st_data_i[7:0]}};
      end
      SizeHalf: begin
        st_dbe_o  = 4'b0011 << st_off_i;
        st_dout_o = {2{st_data_i[15:0]}};
      end
      SizeWord: begin
        st_dbe_o  = 4'b1111;
        st_dout_o = st_data_i;
      end
      default: begin
        st_dbe_o  = 4'b0000;
        st_dout_o = st_data_i;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    ld_shift  = ld_din_i >> {ld_off_i, 3'b000};
    ld_data_o = ld_shift;
    unique case (ld_size_i)
      SizeByte: ld_data_o = {{24{ld_signed_i & ld_shift[7]}}, ld_shift[7:0]};
      SizeHalf: ld_data_o = {{16{ld_signed_i & ld_shift[15]}}, ld_shift[15:0]};
      default:  ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: issues one data-memory access at a time, stalls EXE while busy,
// writes back loads and ALU results, and reports misalignment/size/timeout faults.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RF_A_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEMACC,
  input  logic              LDST,
  input  logic [1:0]        DATA_SIZE,
  input  logic              SIGNED,
  input  logic              RF_OP,
  input  logic [ADDR_W-1:0] RESULT,
  input  logic [RF_A_W-1:0] RD_A,
  input  logic [31:0]       RD,
  output logic              DREQ,
  output logic              DRW,
  output logic [ADDR_W-1:0] DADDR,
  output logic [1:0]        DSIZE,
  output logic [3:0]        DBE,
  output logic [31:0]       DOUT,
  input  logic [31:0]       DIN,
  input  logic              DREADY,
  output logic              STALL,
  output logic              W_VALID,
  output logic [RF_A_W-1:0] WB_A,
  output logic [31:0]       WB_D,
  output logic              FAULT,
  output logic [1:0]        FAULT_CODE
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic              drw_q, drw_d;
  size_e             dsize_q, dsize_d;
  logic [3:0]        dbe_q, dbe_d;
  logic [31:0]       dout_q, dout_d;
  logic              signed_q, signed_d;
  logic              dreq_q, dreq_d;
  logic              w_valid_q, w_valid_d;
  logic [RF_A_W-1:0] wb_a_q, wb_a_d;
  logic [31:0]       wb_d_q, wb_d_d;
  logic              fault_q, fault_d;
  fault_e            fault_code_q, fault_code_d;

  size_e       in_size;
  logic [3:0]  lane_dbe;
  logic [31:0] lane_dout;
  logic [31:0] lane_ld;
  logic [31:0] res32;

  assign in_size = size_e'(DATA_SIZE);

  // ALU results narrower than the data path are zero-extended on write-back.
  if (ADDR_W >= 32) begin : g_res_trunc
    assign res32 = RESULT[31:0];
  end else begin : g_res_ext
    assign res32 = {{(32 - ADDR_W){1'b0}}, RESULT};
  end

  // Store lanes come from the live request; load extraction uses the latched access.
  mem_lsu_lane u_lane (
    .st_off_i   (RESULT[1:0]),
    .st_size_i  (in_size),
    .st_data_i  (RD),
    .st_dbe_o   (lane_dbe),
    .st_dout_o  (lane_dout),
    .ld_off_i   (daddr_q[1:0]),
    .ld_size_i  (dsize_q),
    .ld_signed_i(signed_q),
    .ld_din_i   (DIN),
    .ld_data_o  (lane_ld)
  );

  // Next-state: accept or reject requests in IDLE, complete or time out in BUSY.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    daddr_d      = daddr_q;
    drw_d        = drw_q;
    dsize_d      = dsize_q;
    dbe_d        = dbe_q;
    dout_d       = dout_q;
    signed_d     = signed_q;
    dreq_d       = dreq_q;
    wb_a_d       = wb_a_q;
    wb_d_d       = wb_d_q;
    w_valid_d    = 1'b0;
    fault_d      = 1'b0;
    fault_code_d = FaultNone;

    unique case (state_q)
      StIdle: begin
        if (MEMACC) begin
          if (in_size == SizeNone) begin
            fault_d      = 1'b1;
            fault_code_d = FaultSize;
          end else if (is_misaligned(in_size, RESULT[1:0])) begin
            fault_d      = 1'b1;
            fault_code_d = FaultMisalign;
          end else begin
            daddr_d  = RESULT;
            drw_d    = LDST;
            dsize_d  = in_size;
            dbe_d    = lane_dbe;
            dout_d   = lane_dout;
            signed_d = SIGNED;
            wb_a_d   = RD_A;
            dreq_d   = 1'b1;
            cnt_d    = '0;
            state_d  = StBusy;
          end
        end else if (RF_OP) begin
          w_valid_d = 1'b1;
          wb_a_d    = RD_A;
          wb_d_d    = res32;
        end
      end
      StBusy: begin
        if (DREADY) begin
          dreq_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
          if (drw_q) begin
            w_valid_d = 1'b1;
            wb_d_d    = lane_ld;
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // This was the last BUSY cycle the budget allows.
          dreq_d       = 1'b0;
          cnt_d        = '0;
          state_d      = StIdle;
          fault_d      = 1'b1;
          fault_code_d = FaultTimeout;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      daddr_q      <= '0;
      drw_q        <= 1'b0;
      dsize_q      <= SizeNone;
      dbe_q        <= '0;
      dout_q       <= '0;
      signed_q     <= 1'b0;
      dreq_q       <= 1'b0;
      w_valid_q    <= 1'b0;
      wb_a_q       <= '0;
      wb_d_q       <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FaultNone;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      daddr_q      <= daddr_d;
      drw_q        <= drw_d;
      dsize_q      <= dsize_d;
      dbe_q        <= dbe_d;
      dout_q       <= dout_d;
      signed_q     <= signed_d;
      dreq_q       <= dreq_d;
      w_valid_q    <= w_valid_d;
      wb_a_q       <= wb_a_d;
      wb_d_q       <= wb_d_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign DREQ       = dreq_q;
  assign DRW        = drw_q;
  assign DADDR      = daddr_q;
  assign DSIZE      = dsize_q;
  assign DBE        = dbe_q;
  assign DOUT       = dout_q;
  assign STALL      = (state_q == StBusy);
  assign W_VALID    = w_valid_q;
  assign WB_A       = wb_a_q;
  assign WB_D       = wb_d_q;
  assign FAULT      = fault_q;
  assign FAULT_CODE = fault_code_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random transactions
// compared against a transaction-level model of the access rules.
module tb_mem_lsu;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RF_A_W = 4;
  localparam int unsigned TOUT   = 16;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              MEMACC = 1'b0;
  logic              LDST = 1'b0;
  logic [1:0]        DATA_SIZE = 2'b00;
  logic              SIGNED = 1'b0;
  logic              RF_OP = 1'b0;
  logic [ADDR_W-1:0] RESULT = '0;
  logic [RF_A_W-1:0] RD_A = '0;
  logic [31:0]       RD = '0;
  logic [31:0]       DIN = '0;
  logic              DREADY = 1'b0;
  logic              DREQ, DRW, STALL, W_VALID, FAULT;
  logic [ADDR_W-1:0] DADDR;
  logic [1:0]        DSIZE, FAULT_CODE;
  logic [3:0]        DBE;
  logic [31:0]       DOUT, WB_D;
  logic [RF_A_W-1:0] WB_A;

  int n_checks = 0;
  int n_fail   = 0;

  mem_lsu #(
    .ADDR_W     (ADDR_W),
    .RF_A_W     (RF_A_W),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .MEMACC    (MEMACC),
    .LDST      (LDST),
    .DATA_SIZE (DATA_SIZE),
    .SIGNED    (SIGNED),
    .RF_OP     (RF_OP),
    .RESULT    (RESULT),
    .RD_A      (RD_A),
    .RD        (RD),
    .DREQ      (DREQ),
    .DRW       (DRW),
    .DADDR     (DADDR),
    .DSIZE     (DSIZE),
    .DBE       (DBE),
    .DOUT      (DOUT),
    .DIN       (DIN),
    .DREADY    (DREADY),
    .STALL     (STALL),
    .W_VALID   (W_VALID),
    .WB_A      (WB_A),
    .WB_D      (WB_D),
    .FAULT     (FAULT),
    .FAULT_CODE(FAULT_CODE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write-back, fault and request must never coincide.
  always @(negedge CLK) begin
    if (RESET_N) check_eq("exclusive", 32'(int'(W_VALID) + int'(FAULT) + int'(DREQ) > 1), 32'd0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model helpers: bytes per access, lane enables, replicated store data, load value.
  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_dbe(input int off, input int nb);
    logic [3:0] m;
    for (int b = 0; b < 4; b++) m[b] = (b >= off) && (b < off + nb);
    return m;
  endfunction

  function automatic logic [31:0] model_dout(input logic [31:0] rd, input int nb);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = rd[8*(b % nb) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] din, input int off, input int nb,
                                            input logic sgn);
    longint val, span;
    span = longint'(1) << (8 * nb);
    val  = (longint'(din) >> (8 * off)) % span;
    if (sgn && val >= span / 2) val = val - span;
    return val[31:0];
  endfunction

  // One transaction from IDLE. k: cycle (1-based in BUSY) DREADY is given; 0 = never.
  task automatic do_op(input logic memacc, input logic ldst, input logic [1:0] size,
                       input logic sgn, input logic rfop, input logic [31:0] result,
                       input logic [3:0] rda, input logic [31:0] rd, input logic [31:0] din,
                       input int k, input logic noise);
    int off, nb, n, exp_n;
    logic tout;
    MEMACC = memacc; LDST = ldst; DATA_SIZE = size; SIGNED = sgn; RF_OP = rfop;
    RESULT = result; RD_A = rda; RD = rd;
    tick();
    MEMACC = 1'b0; RF_OP = 1'b0; RESULT = $urandom; RD_A = 4'($urandom); RD = $urandom;
    off = int'(result[1:0]);
    nb  = nbytes(size);
    if (memacc && (nb == 0 || (off % nb) != 0)) begin
      check_eq("fault_pulse", 32'(FAULT), 32'd1);
      check_eq("fault_code", 32'(FAULT_CODE), (nb == 0) ? 32'd2 : 32'd1);
      check_eq("fault_no_dreq", 32'(DREQ), 32'd0);
      check_eq("fault_no_stall", 32'(STALL), 32'd0);
      check_eq("fault_no_wb", 32'(W_VALID), 32'd0);
      tick();
      check_eq("fault_one_cycle", 32'(FAULT), 32'd0);
      check_eq("fault_stays_idle", 32'(DREQ), 32'd0);
    end else if (memacc) begin
      check_eq("dreq_up", 32'(DREQ), 32'd1);
      check_eq("drw", 32'(DRW), 32'(ldst));
      check_eq("daddr", DADDR, result);
      check_eq("dsize", 32'(DSIZE), 32'(size));
      check_eq("dbe", 32'(DBE), 32'(model_dbe(off, nb)));
      check_eq("dout", DOUT, model_dout(rd, nb));
      tout  = !(k >= 1 && k <= int'(TOUT));
      exp_n = tout ? int'(TOUT) : k;
      n = 0;
      while (STALL === 1'b1 && n < int'(TOUT) + 4) begin
        n++;
        check_eq("daddr_hold", DADDR, result);
        check_eq("dbe_hold", 32'(DBE), 32'(model_dbe(off, nb)));
        check_eq("dreq_hold", 32'(DREQ), 32'd1);
        DREADY = (n == k);
        DIN    = (n == k) ? din : $urandom;
        if (noise) begin
          MEMACC = 1'($urandom); RF_OP = 1'($urandom); LDST = 1'($urandom);
          DATA_SIZE = 2'($urandom); RESULT = $urandom;
        end
        tick();
      end
      DREADY = 1'b0; MEMACC = 1'b0; RF_OP = 1'b0;
      check_eq("busy_cycles", 32'(n), 32'(exp_n));
      check_eq("dreq_down", 32'(DREQ), 32'd0);
      check_eq("stall_down", 32'(STALL), 32'd0);
      check_eq("end_fault", 32'(FAULT), 32'(tout));
      check_eq("end_fault_code", 32'(FAULT_CODE), tout ? 32'd3 : 32'd0);
      check_eq("end_wvalid", 32'(W_VALID), 32'(!tout && ldst));
      if (!tout && ldst) begin
        check_eq("ld_wb_a", 32'(WB_A), 32'(rda));
        check_eq("ld_wb_d", WB_D, model_load(din, off, nb, sgn));
      end
      tick();
      check_eq("end_wvalid_pulse", 32'(W_VALID), 32'd0);
      check_eq("end_fault_pulse", 32'(FAULT), 32'd0);
      check_eq("end_no_dreq", 32'(DREQ), 32'd0);
    end else if (rfop) begin
      check_eq("rf_wvalid", 32'(W_VALID), 32'd1);
      check_eq("rf_wb_a", 32'(WB_A), 32'(rda));
      check_eq("rf_wb_d", WB_D, result);
      check_eq("rf_no_dreq", 32'(DREQ), 32'd0);
      tick();
      check_eq("rf_wvalid_pulse", 32'(W_VALID), 32'd0);
    end else begin
      check_eq("nop_wvalid", 32'(W_VALID), 32'd0);
      check_eq("nop_dreq", 32'(DREQ), 32'd0);
      check_eq("nop_fault", 32'(FAULT), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    int          kk;
    // Reset state with reset held.
    #12;
    check_eq("rst_dreq", 32'(DREQ), 32'd0);
    check_eq("rst_stall", 32'(STALL), 32'd0);
    check_eq("rst_wvalid", 32'(W_VALID), 32'd0);
    check_eq("rst_fault", 32'(FAULT), 32'd0);
    check_eq("rst_dbe", 32'(DBE), 32'd0);
    check_eq("rst_wb_d", WB_D, 32'd0);
    RESET_N = 1'b1;
    tick();

    // Signed byte load from the top lane, memory ready on the third BUSY cycle.
    do_op(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h103, 4'd5, 32'h0, 32'h80AABBCC, 3, 1'b0);
    // Half store to the upper half.
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h202, 4'd1, 32'h1234ABCD, 32'h0, 2, 1'b0);
    // Misaligned word load.
    do_op(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 32'h101, 4'd2, 32'h0, 32'h0, 1, 1'b0);
    // Illegal size outranks misalignment.
    do_op(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h101, 4'd2, 32'h0, 32'h0, 1, 1'b0);
    // Load that never gets DREADY.
    do_op(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 32'h400, 4'd3, 32'h0, 32'h0, 0, 1'b0);
    // DREADY on the very last allowed cycle still completes.
    do_op(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h402, 4'd4, 32'h0, 32'hF00D8001, int'(TOUT), 1'b0);
    // MEMACC outranks RF_OP.
    do_op(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 32'h501, 4'd6, 32'h0, 32'h0000EE00, 1, 1'b0);
    do_op(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'hCAFE0001, 4'd9, 32'h0, 32'h0, 0, 1'b0);

    // Reset in the middle of an access: outputs drop at once, nothing is replayed.
    MEMACC = 1'b1; LDST = 1'b1; DATA_SIZE = 2'b11; RESULT = 32'h600; RD_A = 4'd7;
    tick();
    MEMACC = 1'b0;
    check_eq("abort_dreq_up", 32'(DREQ), 32'd1);
    tick();
    #2 RESET_N = 1'b0;
    #1;
    check_eq("abort_dreq", 32'(DREQ), 32'd0);
    check_eq("abort_stall", 32'(STALL), 32'd0);
    check_eq("abort_wvalid", 32'(W_VALID), 32'd0);
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    do_op(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h55, 4'd8, 32'h0, 32'h0, 0, 1'b0);

    // Random transactions.
    for (int i = 0; i < 250; i++) begin
      addr = $urandom;
      sz   = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      // Mostly aligned, sometimes not.
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) addr[0] = 1'b0;
        if (sz == 2'b11) addr[1:0] = 2'b00;
      end
      kk = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
      if ($urandom_range(0, 15) == 0) kk = int'($urandom_range(6, TOUT));
      case ($urandom_range(0, 5))
        0, 1: do_op(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'b1, addr,
                    4'($urandom), $urandom, $urandom, 0, 1'b0);
        2:    do_op(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'b0, addr,
                    4'($urandom), $urandom, $urandom, 0, 1'b0);
        default: do_op(1'b1, 1'($urandom), sz, 1'($urandom), 1'($urandom), addr,
                       4'($urandom), $urandom, $urandom, kk, 1'($urandom));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard against a hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameters SHALL be:
  ADDR_W  32  data-memory address width (>= 8)
  RF_A_W  4  register-file index width
  TIMEOUT_CYC  16  maximum cycles waiting for DREADY before a fault (>= 1)
REQ-002 Data path width SHALL be fixed at 32 bits; DBE SHALL be 4 bits.
REQ-003 Ports SHALL be (clock and reset first):
  CLK  in  1  single clock, rising edge
  RESET_N  in  1  asynchronous, active-low reset
  MEMACC  in  1  memory operation requested by EXE
  LDST  in  1  1 load, 0 store
  DATA_SIZE  in  2  01 byte, 10 half, 11 word, 00 illegal
  SIGNED  in  1  sign-extend load data
  RF_OP  in  1  non-memory result to write back
  RESULT  in  ADDR_W  address (memory op) or ALU result
  RD_A  in  RF_A_W  destination register
  RD  in  32  store data
  DREQ  out  1  data-memory request
  DRW  out  1  1 read, 0 write
  DADDR  out  ADDR_W  byte address
  DSIZE  out  2  copy of accepted DATA_SIZE
  DBE  out  4  byte-lane enables
  DOUT  out  32  lane-replicated store data
  DIN  in  32  read data
  DREADY  in  1  memory completes the current access
  STALL  out  1  EXE must hold its outputs
  W_VALID  out  1  write-back valid
  WB_A  out  RF_A_W  write-back register
  WB_D  out  32  write-back data
  FAULT  out  1  one-cycle fault pulse
  FAULT_CODE  out  2  01 misaligned, 10 illegal size, 11 timeout

Function
REQ-004 FSM states SHALL be IDLE and BUSY; inputs are sampled only in IDLE.
REQ-005 In IDLE, MEMACC=1 with legal, aligned size: next edge registers address, direction, size, DBE, DOUT and RD_A; DREQ=1; state BUSY.
REQ-006 DADDR, DRW, DSIZE, DBE and DOUT SHALL stay stable while DREQ=1.
REQ-007 STALL SHALL equal (state==BUSY).
REQ-008 In BUSY with DREADY=1: DREQ drops next edge; state IDLE; for loads W_VALID=1 with WB_D = extracted DIN for exactly one cycle; stores produce no write-back.
REQ-009 Latency: MEMACC at edge N, DREQ high from N+1, DREADY at edge N+k (k>=1) gives W_VALID in cycle N+k+1.
REQ-010 Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
REQ-011 Misaligned or DATA_SIZE=00 in IDLE: no DREQ; FAULT=1 for one cycle with code 01 or 10 (00 takes priority); no write-back; stays IDLE.
REQ-012 A counter SHALL count BUSY cycles; if it reaches TIMEOUT_CYC without DREADY: DREQ drops, FAULT code 11 pulses, state IDLE, no write-back.
REQ-013 DBE: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
REQ-014 DOUT: byte replicated 4x, half replicated 2x, word unchanged.
REQ-015 Load extract: DIN shifted right by 8*addr[1:0], masked to size, sign-extended if SIGNED=1, else zero-extended.
REQ-016 In IDLE with MEMACC=0 and RF_OP=1: next edge W_VALID=1, WB_A=RD_A, WB_D=RESULT (zero-extended to 32) for one cycle.
REQ-017 MEMACC takes priority over RF_OP when both are 1.
REQ-018 W_VALID, FAULT and DREQ SHALL never be 1 in the same cycle.

Reset
REQ-019 RESET_N low SHALL asynchronously force state IDLE, counter 0 and every output to 0, including DREQ dropping mid-access.
REQ-020 After release, the first sampled input is taken in IDLE; an aborted access is not replayed.

Structure
REQ-021 Package mem_lsu_pkg SHALL hold the state enum, size codes (BYTE/HALF/WORD) and fault codes.
REQ-022 Combinational lane logic (DBE, DOUT replication, load extract/extend) SHALL be the sub-module mem_lsu_lane.

Verification
REQ-023 Load byte, SIGNED=1, addr 0x103, DIN 0x80AABBCC, DREADY after 3 cycles -> DBE 1000, STALL 3 cycles, WB_D 0xFFFFFF80.
REQ-024 Store half, addr 0x202, RD 0x1234ABCD -> DBE 1100, DOUT 0xABCDABCD, DRW 0, no W_VALID.
REQ-025 Load word, addr 0x101 -> FAULT code 01 for one cycle, DREQ never 1.
REQ-026 Load, DREADY held 0, TIMEOUT_CYC 16 -> DREQ drops after 16 BUSY cycles, FAULT code 11, STALL 0.
REQ-027 RESET_N low during BUSY -> DREQ, STALL and W_VALID 0 immediately; next RF_OP RESULT 0x55 gives WB_D 0x55 one cycle later.
